fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the 5-stage pipeline: owns the PC, issues one request
//  at a time to a variable-latency instruction memory (req/ack), and loads the F/D register.
//  Sits between the hazard/branch logic (stall, redirect) and the instruction memory.
//  Handles stall back-pressure and branch/jump redirects, including a redirect that arrives
//  while a fetch is still in flight.
// PARAMETERS
//  RESET_PC  32'h00003000  PC value loaded on reset
//  PC_STEP   4             sequential PC increment, in bytes
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   synchronous, active-high
//  stall          in   1   hazard unit: hold F/D contents this cycle
//  redirect_valid in   1   branch/jump taken: refetch from redirect_pc
//  redirect_pc    in   32  target; bits [1:0] forced to 0 internally
//  mem_req        out  1   fetch request to instruction memory
//  mem_addr       out  32  word-aligned fetch address
//  mem_ack        in   1   memory accepts and returns data this cycle
//  mem_rdata      in   32  instruction; valid only when mem_ack=1
//  fd_valid       out  1   F/D register holds a live instruction
//  fd_instr       out  32  F/D instruction
//  fd_pc          out  32  PC of fd_instr
//  pc             out  32  current fetch PC
// BEHAVIOUR
//  Reset: pc=RESET_PC, mem_req=0, mem_addr=0, fd_valid=0, fd_instr=0, fd_pc=0, state=IDLE.
//   Reset asserted mid-fetch drops mem_req on the next edge. Any ack for that fetch is ignored.
//  FSM states: IDLE, FETCH, HOLD, KILL.
//   IDLE : mem_req=0. Next edge -> FETCH with mem_addr=pc.
//   FETCH: mem_req=1. mem_addr stays stable until ack. On mem_ack:
//          - stall=0: fd_instr=mem_rdata, fd_pc=mem_addr, fd_valid=1, pc+=PC_STEP,
//            stay in FETCH with the new address. Back-to-back acks give 1 instruction/cycle.
//          - stall=1: capture into skid buffer (buf_instr, buf_pc). F/D is unchanged.
//            pc+=PC_STEP. -> HOLD.
//   HOLD : mem_req=0. When stall=0: F/D<=buffer, fd_valid=1, -> FETCH.
//   KILL : mem_req=1, same address (request cannot be withdrawn). On mem_ack:
//          discard data, -> FETCH at pc.
//  Redirect (any state, highest priority after reset):
//   - pc<=redirect_pc&~3, fd_valid<=0 next edge (flush), skid buffer discarded.
//   - FETCH with no ack this cycle -> KILL. Ack in the same cycle -> data dropped, -> FETCH.
//   - HOLD/IDLE -> FETCH. KILL -> stays KILL.
//   - redirect together with stall: redirect wins, flush still happens.
//  Stall with no ack in FETCH: request keeps waiting. fd_* hold their values.
//  fd_valid=0 when no instruction was loaded during a cycle of unstalled F/D update
//   (fetch latency bubble).
//  pc wraps modulo 2^32. No trap on wrap.
//  Only one request is outstanding. mem_req never drops without an ack, except on reset.
// TESTING
//  1 reset, mem_ack tied 1 -> mem_addr 3000,3004,3008 on successive cycles;
//    fd_pc follows one cycle later with fd_valid=1.
//  2 ack after 3-cycle latency -> mem_addr stays 3000 for 3 cycles; fd_valid=0 bubbles,
//    then fd_instr=rdata, fd_pc=3000.
//  3 stall=1 on the ack cycle for 2 cycles -> fd unchanged and mem_req=0 while stalled;
//    after release fd_pc=3004 from buffer, next fetch addr 3008.
//  4 redirect to 0x3103 while waiting for ack -> pc=3100, fd_valid=0; ack for the old
//    request dropped; next mem_addr=3100.
//  5 redirect+stall+ack in the same cycle -> data dropped, fd_valid=0, next mem_addr=redirect.
//  6 reset mid-fetch -> mem_req=0 next edge, pc=3000; late ack ignored; then fetch from 3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the fetch PC and issues one request at a time to a variable-latency
// instruction memory. Fetched instructions are loaded into the F/D register.
// Stalls from the hazard unit and branch/jump redirects are absorbed here,
// including a redirect that lands while a request is still in flight.
//
// Ports
//   clk            clock, rising edge
//   reset          synchronous, active-high
//   stall          hold F/D contents this cycle
//   redirect_valid refetch from redirect_pc (branch/jump taken)
//   redirect_pc    redirect target; low two bits ignored
//   mem_req        fetch request to instruction memory
//   mem_addr       word-aligned fetch address
//   mem_ack        memory accepts the request and returns data this cycle
//   mem_rdata      instruction, valid only with mem_ack
//   fd_valid       F/D register holds a live instruction
//   fd_instr       F/D instruction
//   fd_pc          PC of fd_instr
//   pc             current fetch PC
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        fd_valid,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic [31:0] pc
);

    localparam logic [31:0 ] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        KILL
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_next, mem_addr_next;
    logic        fd_valid_next;
    logic [31:0] fd_instr_next, fd_pc_next;
    logic [31:0] buf_instr, buf_pc, buf_instr_next, buf_pc_next;
    logic [31:0] redirect_target, pc_inc;

    assign redirect_target = redirect_pc & ~32'd3;
    assign pc_inc          = pc + STEP;

    // A request is outstanding in FETCH and KILL; a KILL request cannot be
    // withdrawn, so it stays up until the memory acks it.
    assign mem_req = (state == FETCH) || (state == KILL);

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            mem_addr  <= 32'd0;
            fd_valid  <= 1'b0;
            fd_instr  <= 32'd0;
            fd_pc     <= 32'd0;
            buf_instr <= 32'd0;
            buf_pc    <= 32'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            mem_addr  <= mem_addr_next;
            fd_valid  <= fd_valid_next;
            fd_instr  <= fd_instr_next;
            fd_pc     <= fd_pc_next;
            buf_instr <= buf_instr_next;
            buf_pc    <= buf_pc_next;
        end
    end

    // Next-state and datapath logic. An unstalled cycle that loads nothing
    // leaves a bubble in F/D; a stalled cycle holds F/D as it is.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        mem_addr_next  = mem_addr;
        fd_valid_next  = stall ? fd_valid : 1'b0;
        fd_instr_next  = fd_instr;
        fd_pc_next     = fd_pc;
        buf_instr_next = buf_instr;
        buf_pc_next    = buf_pc;

        if (redirect_valid) begin
            // Redirect flushes F/D even under stall; any ack data this cycle
            // and any skid-buffer contents belong to the wrong path.
            pc_next       = redirect_target;
            fd_valid_next = 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        mem_addr_next = redirect_target;
                    end else begin
                        state_next = KILL;
                    end
                end
                IDLE, HOLD: begin
                    state_next    = FETCH;
                    mem_addr_next = redirect_target;
                end
                default: state_next = KILL;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state_next    = FETCH;
                    mem_addr_next = pc;
                end
                FETCH: begin
                    if (mem_ack) begin
                        pc_next = pc_inc;
                        if (stall) begin
                            buf_instr_next = mem_rdata;
                            buf_pc_next    = mem_addr;
                            state_next     = HOLD;
                        end else begin
                            fd_instr_next = mem_rdata;
                            fd_pc_next    = mem_addr;
                            fd_valid_next = 1'b1;
                            mem_addr_next = pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fd_instr_next = buf_instr;
                        fd_pc_next    = buf_pc;
                        fd_valid_next = 1'b1;
                        state_next    = FETCH;
                        mem_addr_next = pc;
                    end
                end
                default: begin
                    // KILL: the wrong-path reply is dropped, then refetch at pc.
                    if (mem_ack) begin
                        state_next    = FETCH;
                        mem_addr_next = pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expFv;
        logic [31:0] expFpc;
        logic [31:0] expFi;
        logic [31:0] expPc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbQueue[$];

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .fd_valid       (fd_valid),
        .fd_instr       (fd_instr),
        .fd_pc          (fd_pc),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                          input logic a, input logic [31:0] d, input logic eReq, input logic [31:0] eAddr,
                          input logic eFv, input logic [31:0] eFpc, input logic [31:0] eFi, input logic [31:0] ePc);
        vec_t v;
        v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.ack = a; v.rdata = d;
        v.expReq = eReq; v.expAddr = eAddr; v.expFv = eFv; v.expFpc = eFpc; v.expFi = eFi; v.expPc = ePc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        mem_ack        = v.ack;
        mem_rdata      = v.rdata;
    endtask

    initial begin
        vec_t v;
        int lat;
        int waitc;
        logic [31:0] expAddr;
        logic stallApplied;
        sb_t e;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        //      rst st rv rpc            ack rdata          req addr           fv fpc            fi             pc
        addVec(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3000,      0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         1, 32'hA0A0_0000, 1, 32'h3004,      1, 32'h3000,      32'hA0A0_0000, 32'h3004);
        addVec(0, 0, 0, 32'h0,         1, 32'hA1A1_0001, 1, 32'h3008,      1, 32'h3004,      32'hA1A1_0001, 32'h3008);
        addVec(0, 0, 0, 32'h0,         1, 32'hA2A2_0002, 1, 32'h300C,      1, 32'h3008,      32'hA2A2_0002, 32'h300C);
        addVec(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3000,      0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3000,      0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3000,      0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         1, 32'hB0B0_0000, 1, 32'h3004,      1, 32'h3000,      32'hB0B0_0000, 32'h3004);
        addVec(0, 1, 0, 32'h0,         1, 32'hB1B1_0001, 0, 32'h3004,      1, 32'h3000,      32'hB0B0_0000, 32'h3008);
        addVec(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h3004,      1, 32'h3000,      32'hB0B0_0000, 32'h3008);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3008,      1, 32'h3004,      32'hB1B1_0001, 32'h3008);
        addVec(0, 0, 1, 32'h3103,      0, 32'h0,         1, 32'h3008,      0, 32'h3004,      32'hB1B1_0001, 32'h3100);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3008,      0, 32'h3004,      32'hB1B1_0001, 32'h3100);
        addVec(0, 0, 0, 32'h0,         1, 32'hDEAD_0000, 1, 32'h3100,      0, 32'h3004,      32'hB1B1_0001, 32'h3100);
        addVec(0, 0, 0, 32'h0,         1, 32'hC1C1_0001, 1, 32'h3104,      1, 32'h3100,      32'hC1C1_0001, 32'h3104);
        addVec(0, 1, 1, 32'h3200,      1, 32'hDEAD_0001, 1, 32'h3200,      0, 32'h3100,      32'hC1C1_0001, 32'h3200);
        addVec(0, 0, 0, 32'h0,         1, 32'hC3C3_0003, 1, 32'h3204,      1, 32'h3200,      32'hC3C3_0003, 32'h3204);
        addVec(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h3204,      0, 32'h3200,      32'hC3C3_0003, 32'h3204);
        addVec(1, 0, 0, 32'h0,         1, 32'hDEAD_0002, 0, 32'h0,         0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         1, 32'hDEAD_0003, 1, 32'h3000,      0, 32'h0,         32'h0,         32'h3000);
        addVec(0, 0, 0, 32'h0,         1, 32'hD0D0_0000, 1, 32'h3004,      1, 32'h3000,      32'hD0D0_0000, 32'h3004);
        addVec(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,         1, 32'h3004,      0, 32'h3000,      32'hD0D0_0000, 32'hFFFF_FFFC);
        addVec(0, 0, 0, 32'h0,         1, 32'hDEAD_0004, 1, 32'hFFFF_FFFC, 0, 32'h3000,      32'hD0D0_0000, 32'hFFFF_FFFC);
        addVec(0, 0, 0, 32'h0,         1, 32'hE0E0_0000, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'hE0E0_0000, 32'h0);
        addVec(0, 1, 0, 32'h0,         1, 32'hE1E1_0001, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hE0E0_0000, 32'h4);
        addVec(0, 1, 1, 32'h3300,      0, 32'h0,         1, 32'h3300,      0, 32'hFFFF_FFFC, 32'hE0E0_0000, 32'h3300);
        addVec(0, 0, 0, 32'h0,         1, 32'hE2E2_0002, 1, 32'h3304,      1, 32'h3300,      32'hE2E2_0002, 32'h3304);

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            applyStimulus(v);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, v.expReq});
            checkOutput($sformatf("v%0d mem_addr", i), mem_addr, v.expAddr);
            checkOutput($sformatf("v%0d fd_valid", i), {31'd0, fd_valid}, {31'd0, v.expFv});
            checkOutput($sformatf("v%0d fd_pc", i), fd_pc, v.expFpc);
            checkOutput($sformatf("v%0d fd_instr", i), fd_instr, v.expFi);
            checkOutput($sformatf("v%0d pc", i), pc, v.expPc);
        end

        // Streaming phase: random memory latency and random stalls, every
        // accepted instruction must come out of F/D exactly once and in order.
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        expAddr = 32'h3000;
        lat = $urandom_range(0, 3);
        waitc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 9) < 3);
            mem_ack = 1'b0;
            mem_rdata = 32'd0;
            if (mem_req) begin
                if (waitc >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = memWord(expAddr);
                    checkOutput("stream mem_addr", mem_addr, expAddr);
                    e.addr = expAddr;
                    e.instr = memWord(expAddr);
                    sbQueue.push_back(e);
                    expAddr = expAddr + 32'd4;
                    waitc = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    waitc++;
                end
            end
            stallApplied = stall;
            @(posedge clk);
            #1;
            if (!stallApplied && fd_valid) begin
                if (sbQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL stream unexpected load: fd_pc %h expected no instruction", fd_pc);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("stream fd_pc", fd_pc, e.addr);
                    checkOutput("stream fd_instr", fd_instr, e.instr);
                end
            end
        end

        // Drain: release stall so any buffered instruction reaches F/D.
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            stall = 1'b0;
            mem_ack = 1'b0;
            @(posedge clk);
            #1;
            if (fd_valid && sbQueue.size() != 0) begin
                e = sbQueue.pop_front();
                checkOutput("drain fd_pc", fd_pc, e.addr);
                checkOutput("drain fd_instr", fd_instr, e.instr);
            end
        end
        checkOutput("scoreboard empty", 32'(sbQueue.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
